// File: rtl/sd_sector_scan_if.sv
// Handshake between the SD read engine and the sector-scan controller:
// read request/address one way, byte stream and sector-complete back.
interface sd_sector_scan_if;
  logic        read_req;
  logic [31:0] read_sec;
  logic [7:0]  mydata_o;
  logic        myvalid_o;
  logic        read_o;

  modport master (
    output read_req, read_sec,
    input  mydata_o, myvalid_o, read_o
  );

  modport slave (
    input  read_req, read_sec,
    output mydata_o, myvalid_o, read_o
  );
endinterface

// File: rtl/sd_sector_scan.sv
// Sector-scan controller: walks a window of SD sectors through the read engine
// and captures the first non-zero byte seen at two fixed byte offsets.
//
//   state  | meaning
//   IDLE   | card not initialised, waiting for init_o
//   WAIT   | start-up delay after init_o
//   REQ    | read_req asserted, waiting for the first byte
//   RECV   | receiving bytes of the current sector
//   GAP    | idle spacing before the next sector request
//   DONE   | scan finished (window exhausted, both found, or timeout)
module sd_sector_scan #(
  parameter logic [31:0] BASE_SEC    = 32'd16640,
  parameter int          NUM_SEC     = 32,
  parameter int          START_DELAY = 1022,
  parameter int          OFF_A       = 2,
  parameter int          OFF_B       = 0,
  parameter int          GAP         = 8,
  parameter int          TIMEOUT     = 65535
) (
  input  logic             SD_clk,
  input  logic             rst_n,
  input  logic             init_o,
  sd_sector_scan_if.master rd,
  output logic [7:0]       number1,
  output logic [7:0]       number2,
  output logic             done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_RECV, S_GAP, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] dly_cnt;
  logic [31:0] to_cnt;
  logic [15:0] sec_idx;
  logic [8:0]  off;
  logic        full;
  logic        lock_a, lock_b;

  logic in_xfer, take_byte, overrun, hit_a, hit_b;
  logic lock_a_nxt, lock_b_nxt, full_nxt, sec_end, timeout, last_sec;
  state_t fin_state;

  always_comb begin
    in_xfer    = init_o && (state == S_REQ || state == S_RECV);
    take_byte  = in_xfer && rd.myvalid_o && !full;
    overrun    = in_xfer && rd.myvalid_o && full;
    hit_a      = take_byte && !lock_a && (off == 9'(OFF_A)) && (rd.mydata_o != 8'd0);
    hit_b      = take_byte && !lock_b && (off == 9'(OFF_B)) && (rd.mydata_o != 8'd0);
    lock_a_nxt = lock_a || hit_a;
    lock_b_nxt = lock_b || hit_b;
    full_nxt   = full || (take_byte && off == 9'd511);
    // a byte arriving with read_o is counted before the sector is closed
    sec_end    = in_xfer && rd.read_o;
    timeout    = in_xfer && !rd.read_o && (to_cnt == 32'd0);
    last_sec   = (sec_idx == 16'(NUM_SEC - 1));
    fin_state  = ((lock_a_nxt && lock_b_nxt) || last_sec) ? S_DONE : S_GAP;

    state_nxt = state;
    case (state)
      S_IDLE: if (init_o) state_nxt = S_WAIT;
      S_WAIT: if (dly_cnt == 32'd0) state_nxt = S_REQ;
      S_REQ: begin
        if (sec_end)           state_nxt = fin_state;
        else if (timeout)      state_nxt = S_DONE;
        else if (rd.myvalid_o) state_nxt = S_RECV;
      end
      S_RECV: begin
        if (sec_end)      state_nxt = fin_state;
        else if (timeout) state_nxt = S_DONE;
      end
      S_GAP:  if (dly_cnt == 32'd0) state_nxt = S_REQ;
      S_DONE: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (!init_o) state_nxt = S_IDLE;
  end

  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rd.read_req <= 1'b0;
      rd.read_sec <= BASE_SEC;
      number1     <= 8'd0;
      number2     <= 8'd0;
      done        <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      dly_cnt     <= 32'd0;
      to_cnt      <= 32'd0;
      sec_idx     <= 16'd0;
      off         <= 9'd0;
      full        <= 1'b0;
      lock_a      <= 1'b0;
      lock_b      <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd.read_req <= (state_nxt == S_REQ);
      busy        <= (state_nxt inside {S_REQ, S_RECV, S_GAP});
      done        <= (state_nxt == S_DONE);

      // shared down-counter: start-up delay in WAIT, spacing in GAP
      if (state == S_IDLE)        dly_cnt <= 32'(START_DELAY);
      else if (sec_end)           dly_cnt <= 32'(GAP);
      else if (dly_cnt != 32'd0)  dly_cnt <= dly_cnt - 32'd1;

      if (state_nxt == S_REQ && state != S_REQ) begin
        to_cnt <= 32'(TIMEOUT - 1);
        off    <= 9'd0;
        full   <= 1'b0;
        if (state == S_WAIT) begin
          rd.read_sec <= BASE_SEC;
          sec_idx     <= 16'd0;
        end else begin
          rd.read_sec <= rd.read_sec + 32'd1;
          sec_idx     <= sec_idx + 16'd1;
        end
      end else begin
        if (in_xfer && to_cnt != 32'd0) to_cnt <= to_cnt - 32'd1;
        if (take_byte) begin
          if (off == 9'd511) full <= 1'b1;
          else               off  <= off + 9'd1;
        end
      end

      if (hit_a) begin
        number1 <= rd.mydata_o;
        lock_a  <= 1'b1;
      end
      if (hit_b) begin
        number2 <= rd.mydata_o;
        lock_b  <= 1'b1;
      end

      if (overrun || (sec_end && !full_nxt) || timeout) err <= 1'b1;
    end
  end

endmodule
